// File: rtl/turbo_clk_ctrl_if.sv
// Control bus of turbo_clk_ctrl: rate selection, bus-master hold and the
// clock-enable output. The master side is the requester; the controller
// uses the slave modport.
//
// Handshakes:
//   iSel/iSelStb -> oSelBusy: a one-cycle iSelStb with oSelBusy=0 latches
//     iSel and raises oSelBusy. oSelBusy falls on the edge that applies the
//     change, and oSelCur takes the new index on that same edge. A strobe
//     while oSelBusy=1 is dropped.
//   iHoldReq -> oHoldAck: iHoldReq is a level. The controller finishes its
//     current enable period, emits one last pulse, stops, and raises
//     oHoldAck one edge later. Dropping iHoldReq clears oHoldAck on the next
//     edge, and pulses resume.
// oDbgState shows the FSM state (0 = RUN, 1 = HOLD).
interface turbo_clk_ctrl_if;
    logic [1:0] iSel;
    logic       iSelStb;
    logic       oSelBusy;
    logic [1:0] oSelCur;
    logic       iHoldReq;
    logic       oHoldAck;
    logic       oClkEn;
    logic       oDbgState;

    modport master (
        output iSel, iSelStb, iHoldReq,
        input  oSelBusy, oSelCur, oHoldAck, oClkEn, oDbgState
    );

    modport slave (
        input  iSel, iSelStb, iHoldReq,
        output oSelBusy, oSelCur, oHoldAck, oClkEn, oDbgState
    );
endinterface

// File: rtl/turbo_clk_ctrl.sv
// Fractional clock-enable generator with four selectable rates. A Bresenham
// accumulator produces exactly RATE[oSelCur] enable pulses per CLK_IN
// clocks. Rate changes are deferred to a pulse edge, so a pulse period is
// never cut short.
// Optional feature: define TURBO_CLK_HOLD_EN to compile in the bus-master
// hold (HOLD state, iHoldReq, oHoldAck). Without the macro, iHoldReq is
// ignored, oHoldAck stays 0 and the FSM never leaves RUN.
module turbo_clk_ctrl #(
    parameter int CLK_IN = 25000000,
    parameter int RATE0  = 4772727,
    parameter int RATE1  = 7159090,
    parameter int RATE2  = 9545454,
    parameter int RATE3  = 12500000,
    parameter int ACC_W  = 27
) (
    input  logic             iClk,
    input  logic             iRst,
    turbo_clk_ctrl_if.slave  bus
);
    typedef enum logic {ST_RUN = 1'b0, ST_HOLD = 1'b1} state_t;

    localparam logic [ACC_W-1:0] CLK_V = ACC_W'(CLK_IN);

    state_t           state, state_nxt;
    logic [ACC_W-1:0] acc, acc_nxt;
    logic [1:0]       cur, cur_nxt;
    logic [1:0]       pend, pend_nxt;
    logic             busy, busy_nxt;
    logic             en, en_nxt;
    logic             ack, ack_nxt;
    logic             cmp;

    function automatic logic [ACC_W-1:0] rate_of(input logic [1:0] idx);
        logic [ACC_W-1:0] r;
        case (idx)
            2'd0:    r = ACC_W'(RATE0);
            2'd1:    r = ACC_W'(RATE1);
            2'd2:    r = ACC_W'(RATE2);
            default: r = ACC_W'(RATE3);
        endcase
        return r;
    endfunction

`ifndef TURBO_CLK_HOLD_EN
    logic unused_hold;
    assign unused_hold = bus.iHoldReq;
`endif

    // Next-state logic: accumulator step, pending-change capture and apply, hold entry and exit.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cur_nxt   = cur;
        pend_nxt  = pend;
        busy_nxt  = busy;
        en_nxt    = 1'b0;
        ack_nxt   = ack;
        cmp       = (acc >= CLK_V);

        // Capture runs in every state. A capture only happens when busy=0,
        // so it never competes with the apply below, which needs busy=1.
        if (bus.iSelStb && !busy) begin
            pend_nxt = bus.iSel;
            busy_nxt = 1'b1;
        end

        case (state)
            ST_RUN: begin
                if (cmp) begin
                    en_nxt = 1'b1;
                    if (busy) begin
                        acc_nxt  = acc - CLK_V + rate_of(pend);
                        cur_nxt  = pend;
                        busy_nxt = 1'b0;
                    end else begin
                        acc_nxt  = acc - CLK_V + rate_of(cur);
                    end
`ifdef TURBO_CLK_HOLD_EN
                    // The last pulse before a hold is the one on this edge.
                    if (bus.iHoldReq) begin
                        state_nxt = ST_HOLD;
                    end
`endif
                end else begin
                    acc_nxt = acc + rate_of(cur);
                end
            end
            ST_HOLD: begin
`ifdef TURBO_CLK_HOLD_EN
                // The accumulator stays frozen. The acknowledge follows the request level.
                if (bus.iHoldReq) begin
                    ack_nxt = 1'b1;
                end else begin
                    ack_nxt   = 1'b0;
                    state_nxt = ST_RUN;
                end
`else
                state_nxt = ST_RUN;
`endif
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    // State registers with synchronous reset. Reset discards any pending change or hold.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state <= ST_RUN;
            acc   <= '0;
            cur   <= 2'd0;
            pend  <= 2'd0;
            busy  <= 1'b0;
            en    <= 1'b0;
            ack   <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cur   <= cur_nxt;
            pend  <= pend_nxt;
            busy  <= busy_nxt;
            en    <= en_nxt;
            ack   <= ack_nxt;
        end
    end

    assign bus.oClkEn    = en;
    assign bus.oSelCur   = cur;
    assign bus.oSelBusy  = busy;
    assign bus.oHoldAck  = ack;
    assign bus.oDbgState = (state == ST_HOLD);
endmodule

// File: tb/tb_turbo_clk_ctrl.sv
// Bench for turbo_clk_ctrl with CLK_IN=10 and rates 1, 2, 5, 10.
// Directed scenarios come first, followed by a randomized run. The reference
// model advances once per clock edge using the rate rules written as plain
// integer arithmetic.
module tb_turbo_clk_ctrl;
    logic clk;
    logic rst;

    turbo_clk_ctrl_if bus ();

    turbo_clk_ctrl #(
        .CLK_IN(10), .RATE0(1), .RATE1(2), .RATE2(5), .RATE3(10), .ACC_W(27)
    ) dut (
        .iClk(clk),
        .iRst(rst),
        .bus (bus)
    );

    // Clock and reset defaults.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    int rates[4] = '{1, 2, 5, 10};
    int m_acc    = 0;
    int m_cur    = 0;
    int m_pend   = 0;
    bit m_busy   = 0;
    bit m_en     = 0;
    bit m_hold   = 0;
    bit m_ack    = 0;

`ifdef TURBO_CLK_HOLD_EN
    localparam bit HOLD_ON = 1'b1;
`else
    localparam bit HOLD_ON = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Model of one clock edge. The inputs are the values the DUT samples on that edge.
    task automatic model_edge(input int sel, input bit stb, input bit hold, input bit r);
        bit capture;
        if (r) begin
            m_acc = 0; m_cur = 0; m_pend = 0; m_busy = 0;
            m_en = 0; m_hold = 0; m_ack = 0;
            return;
        end
        capture = stb && !m_busy;
        if (!m_hold) begin
            if (m_acc >= 10) begin
                if (m_busy) begin
                    m_cur  = m_pend;
                    m_busy = 0;
                end
                m_acc = m_acc - 10 + rates[m_cur];
                m_en  = 1;
                if (HOLD_ON && hold) m_hold = 1;
            end else begin
                m_acc = m_acc + rates[m_cur];
                m_en  = 0;
            end
        end else begin
            m_en = 0;
            if (hold) m_ack = 1;
            else begin
                m_ack  = 0;
                m_hold = 0;
            end
        end
        if (capture) begin
            m_pend = sel;
            m_busy = 1;
        end
    endtask

    // Driver: apply the inputs, take one edge, and check every output against the model.
    task automatic step(input logic [1:0] sel, input logic stb, input logic hold, input logic r);
        bus.iSel     = sel;
        bus.iSelStb  = stb;
        bus.iHoldReq = hold;
        rst          = r;
        @(posedge clk);
        model_edge(int'(sel), stb, hold, r);
        #1;
        chk("clken", bus.oClkEn, m_en);
        chk("sel_cur", bus.oSelCur, m_cur);
        chk("sel_busy", bus.oSelBusy, m_busy);
        chk("hold_ack", bus.oHoldAck, m_ack);
        chk("dbg_state", bus.oDbgState, m_hold);
        @(negedge clk);
    endtask

    int cnt;
    int last;
    int first;
    bit hold_lvl;

    initial begin
        bus.iSel = 2'd0; bus.iSelStb = 1'b0; bus.iHoldReq = 1'b0; rst = 1'b1;
        @(negedge clk);

        // Reset state.
        repeat (3) step(2'd0, 1'b0, 1'b0, 1'b1);
        chk("reset_clken", bus.oClkEn, 0);
        chk("reset_cur", bus.oSelCur, 0);
        chk("reset_busy", bus.oSelBusy, 0);
        chk("reset_ack", bus.oHoldAck, 0);

        // Rate 0: 10 pulses per 100 edges, spaced exactly 10 apart.
        cnt = 0; last = 0;
        for (int i = 1; i <= 110; i++) begin
            step(2'd0, 1'b0, 1'b0, 1'b0);
            if (bus.oClkEn === 1'b1) begin
                if (i > 10) cnt++;
                if (last != 0) chk("rate0_spacing", i - last, 10);
                last = i;
            end
        end
        chk("rate0_pulses", cnt, 10);
        chk("rate0_first_pulse", last - 90, 11);

        // Change to index 2. A second strobe while busy is ignored.
        step(2'd2, 1'b1, 1'b0, 1'b0);
        chk("busy_after_strobe", bus.oSelBusy, 1);
        step(2'd3, 1'b1, 1'b0, 1'b0);
        chk("busy_second_strobe", bus.oSelBusy, 1);
        chk("cur_still_0", bus.oSelCur, 0);
        for (int k = 0; k < 30 && bus.oSelCur !== 2'd2; k++) step(2'd0, 1'b0, 1'b0, 1'b0);
        chk("cur_changed_to_2", bus.oSelCur, 2);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            step(2'd0, 1'b0, 1'b0, 1'b0);
            if (bus.oClkEn === 1'b1) cnt++;
        end
        chk("rate2_pulses", cnt, 50);
        chk("rate_settles_2", bus.oSelCur, 2);

        // Rate 3, then a hold request and its release.
        step(2'd3, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 10 && bus.oSelCur !== 2'd3; k++) step(2'd0, 1'b0, 1'b0, 1'b0);
        chk("cur_changed_to_3", bus.oSelCur, 3);
        step(2'd0, 1'b0, 1'b1, 1'b0);
        chk("hold_final_pulse", bus.oClkEn, 1);
        step(2'd0, 1'b0, 1'b1, 1'b0);
        chk("hold_ack_rises", bus.oHoldAck, HOLD_ON);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step(2'd0, 1'b0, 1'b1, 1'b0);
            if (bus.oClkEn === 1'b1) cnt++;
        end
        chk("hold_pulses", cnt, HOLD_ON ? 0 : 20);
        step(2'd0, 1'b0, 1'b0, 1'b0);
        chk("hold_ack_falls", bus.oHoldAck, 0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step(2'd0, 1'b0, 1'b0, 1'b0);
            if (bus.oClkEn === 1'b1) cnt++;
        end
        chk("resume_pulses", cnt, 10);

        // Strobe to index 1 during a hold. The change is applied at the first pulse after resume.
        step(2'd0, 1'b0, 1'b1, 1'b0);
        step(2'd1, 1'b1, 1'b1, 1'b0);
        repeat (5) step(2'd0, 1'b0, 1'b1, 1'b0);
        chk("busy_in_hold", bus.oSelBusy, HOLD_ON);
        step(2'd0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 20 && bus.oClkEn !== 1'b1; k++) step(2'd0, 1'b0, 1'b0, 1'b0);
        chk("cur_at_first_resume_pulse", bus.oSelCur, 1);
        chk("busy_cleared_at_pulse", bus.oSelBusy, 0);
        repeat (10) step(2'd0, 1'b0, 1'b0, 1'b0);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            step(2'd0, 1'b0, 1'b0, 1'b0);
            if (bus.oClkEn === 1'b1) cnt++;
        end
        chk("rate1_pulses", cnt, 20);

        // Reset during a pending change in hold, then time the first pulse after release.
        for (int k = 0; k < 30 && bus.oHoldAck !== 1'b1; k++) step(2'd0, 1'b0, 1'b1, 1'b0);
        step(2'd2, 1'b1, 1'b1, 1'b0);
        chk("busy_before_reset", bus.oSelBusy, 1);
        step(2'd0, 1'b0, 1'b1, 1'b1);
        chk("rst_clken", bus.oClkEn, 0);
        chk("rst_cur", bus.oSelCur, 0);
        chk("rst_busy", bus.oSelBusy, 0);
        chk("rst_ack", bus.oHoldAck, 0);
        chk("rst_state", bus.oDbgState, 0);
        first = 0;
        for (int k = 1; k <= 20; k++) begin
            step(2'd0, 1'b0, 1'b0, 1'b0);
            if (bus.oClkEn === 1'b1 && first == 0) first = k;
        end
        chk("first_pulse_after_reset", first, 11);

        // Randomized traffic checked against the model on every edge.
        hold_lvl = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 19) == 0) hold_lvl = ~hold_lvl;
            step(2'($urandom_range(0, 3)),
                 ($urandom_range(0, 7) == 0),
                 hold_lvl,
                 ($urandom_range(0, 299) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
